serial_preamble_tx: RTL

//  Serial frame transmitter; the transmit end of the 1-bit serial link whose receive side is a preamble-detecting FSM.

---
 rtl/serial_tx_pkg.sv | 25 ++
 rtl/serial_preamble_tx_if.sv | 30 +++
 rtl/serial_piso.sv | 49 ++++
 rtl/serial_preamble_tx.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial preamble transmitter.
//   tx_state_t : transmitter FSM state encoding (also exposed on the debug port)
//   PRE_BIT    : level driven during the preamble
//   GUARD_BIT  : level driven during the trailing guard
//   max3       : helper for sizing the shared down-counter
package serial_tx_pkg;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_PRE   = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_GUARD = 3'd4
  } tx_state_t;

  localparam logic PRE_BIT   = 1'b1;
  localparam logic GUARD_BIT = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_preamble_tx_if.sv
// Word-in / bit-out bundle of the serial preamble transmitter.
//   in_valid  producer has a word         in_ready  transmitter can take a word
//   in_data   payload word                out       serial bit
//   out_valid out carries a frame bit     busy      frame in progress
//   done      pulse with the last guard bit
// Handshake: a word transfers on a rising clk edge where in_valid and in_ready
// are both high. in_data is only looked at on that edge; the producer may
// change it freely at any other time. in_ready never depends on in_valid.
// Modports: slave = transmitter side, master = producer / line-monitor side.
interface serial_preamble_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out;
  logic              out_valid;
  logic              busy;
  logic              done;

  modport slave (
    input  in_valid, in_data,
    output in_ready, out, out_valid, busy, done
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, out, out_valid, busy, done
  );
endinterface

// File: rtl/serial_piso.sv
// Parallel-in serial-out shifter for the payload, LSB first.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture din (takes priority over shift)
//   shift      : advance one bit toward the LSB
//   din        : parallel payload
//   sout       : current LSB of the held word
//   parity     : even parity of the captured word (only with SERIAL_TX_PARITY_EN)
// Optional feature macro: SERIAL_TX_PARITY_EN.
module serial_piso #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
`ifdef SERIAL_TX_PARITY_EN
  output logic              parity,
`endif
  output logic              sout
);

  logic [DATA_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      // Logical shift keeps DATA_W=1 legal (no sub-range slice needed).
      sr <= sr >> 1;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Parity is frozen at load time so it reflects the word as accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= ^din;
    end
  end
`endif

  assign sout = sr[0];

endmodule

// File: rtl/serial_preamble_tx.sv
// Serial frame transmitter: takes a word over valid/ready and emits, one bit
// per clock, PRE_LEN ones, DATA_W payload bits LSB first, an optional even
// parity bit, then GUARD_LEN zeros.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : serial_preamble_tx_if.slave (in_valid/in_ready/in_data,
//                out/out_valid/busy/done)
//   dbg_state  : current FSM state
// Optional feature macro: SERIAL_TX_PARITY_EN (adds the TX_PAR state).
module serial_preamble_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PRE_LEN   = 3,
  parameter int GUARD_LEN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_preamble_tx_if.slave   bus,
  output tx_state_t             dbg_state
);

  localparam int MAX_LEN = max3(PRE_LEN, DATA_W, GUARD_LEN);
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  tx_state_t        state;
  logic [CNT_W-1:0] cnt;      // bits left in the current state, minus one
  logic             out_q;
  logic             out_valid_q;
  logic             done_q;
  logic             accept;
  logic             shift_en;
  logic             piso_bit;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_bit;
`endif

  assign accept   = bus.in_valid && (state == TX_IDLE);
  // A payload bit leaves the shifter on every edge that registers one onto out.
  assign shift_en = ((state == TX_PRE)  && (cnt == '0)) ||
                    ((state == TX_DATA) && (cnt != '0));

  serial_piso #(.DATA_W(DATA_W)) u_piso (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .shift  (shift_en),
    .din    (bus.in_data),
`ifdef SERIAL_TX_PARITY_EN
    .parity (par_bit),
`endif
    .sout   (piso_bit)
  );

  // out/out_valid/done are registered alongside the state so that each
  // registered bit belongs to the state being entered on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= TX_IDLE;
      cnt         <= '0;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (accept) begin
            state       <= TX_PRE;
            cnt         <= CNT_W'(PRE_LEN - 1);
            out_q       <= PRE_BIT;
            out_valid_q <= 1'b1;
          end else begin
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        TX_PRE: begin
          if (cnt == '0) begin
            state <= TX_DATA;
            cnt   <= CNT_W'(DATA_W - 1);
            out_q <= piso_bit;
          end else begin
            cnt   <= cnt - 1'b1;
            out_q <= PRE_BIT;
          end
        end
        TX_DATA: begin
          if (cnt == '0) begin
`ifdef SERIAL_TX_PARITY_EN
            state <= TX_PAR;
            cnt   <= '0;
            out_q <= par_bit;
`else
            state  <= TX_GUARD;
            cnt    <= CNT_W'(GUARD_LEN - 1);
            out_q  <= GUARD_BIT;
            done_q <= (GUARD_LEN == 1);
`endif
          end else begin
            cnt   <= cnt - 1'b1;
            out_q <= piso_bit;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        TX_PAR: begin
          state  <= TX_GUARD;
          cnt    <= CNT_W'(GUARD_LEN - 1);
          out_q  <= GUARD_BIT;
          done_q <= (GUARD_LEN == 1);
        end
`endif
        TX_GUARD: begin
          if (cnt == '0) begin
            state       <= TX_IDLE;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
          end else begin
            cnt    <= cnt - 1'b1;
            out_q  <= GUARD_BIT;
            done_q <= (cnt == CNT_W'(1));
          end
        end
        default: begin
          state       <= TX_IDLE;
          cnt         <= '0;
          out_q       <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == TX_IDLE);
  assign bus.busy      = (state != TX_IDLE);
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;
  assign dbg_state     = state;

endmodule
